// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and divider helpers for the UART receiver
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

  function automatic int calc_div(input int clk_freq, input int bode_rate);
    return clk_freq / bode_rate;
  endfunction

  function automatic int calc_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous single-bit input
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with valid/ready output, framing and overrun flags
// Optional 2-of-3 majority sampling when UART_RX_MAJORITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BODE_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int DIV = calc_div(CLK_FREQ, BODE_RATE);
  localparam int CW  = calc_cnt_w(DIV);
  localparam int IW  = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
  // Decision lands one count after the mid-point; the one-cycle slip carries
  // through the data bits because their counting starts one cycle later too.
  localparam int MIN_DIV = 6;
  localparam int START_T = DIV / 2;
`else
  localparam int MIN_DIV = 4;
  localparam int START_T = DIV / 2 - 1;
`endif

  localparam logic [CW-1:0] START_HIT = CW'(START_T);
  localparam logic [CW-1:0] BIT_HIT   = CW'(DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  generate
    if (DIV < MIN_DIV) begin : g_div_check
      $error("uart_rx: CLK_FREQ/BODE_RATE too small");
    end
  endgenerate

  logic rx_s;
  logic sample;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hist <= 2'b11;
    else      hist <= {hist[0], rx_s};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  rx_state_t           state, state_n;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                cnt_clr, idx_clr, idx_inc, shift_en, deliver, ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    ferr     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == START_HIT) begin
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          state_n = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_HIT) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (idx == LAST_IDX) state_n = STOP;
          else                 idx_inc = 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_HIT) begin
          cnt_clr = 1'b1;
          if (sample) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_clr = 1'b1;
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      idx     <= '0;
      shift_q <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + IW'(1);
      if (shift_en) shift_q[idx] <= sample;
    end
  end

  // A simultaneous accept frees the slot, so the new byte can replace the old one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data       <= 8'h00;
      rx_data_valid <= 1'b0;
      frame_error   <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_error <= ferr;
      overrun     <= 1'b0;
      if (deliver) begin
        if (!rx_data_valid || rx_data_ready) begin
          rx_data       <= shift_q;
          rx_data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_data_valid && rx_data_ready) begin
        rx_data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver: the downstream partner of uart_tx. It takes an asynchronous 8N1 line (idle high, start 0, 8 data bits LSB-first, stop 1) and delivers parallel bytes over a valid/ready handshake. It also flags framing errors and overruns. It uses the same CLK_FREQ/BODE_RATE parameterisation as uart_tx, so a loopback uart_tx.tx -> uart_rx.rx works without changes.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz.
BODE_RATE, 115_200, line bit rate in bit/s. DIV = CLK_FREQ/BODE_RATE (integer division). Elaboration fails if DIV < 4.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
rx  input  1  asynchronous serial line; idle 1.
rx_data  output  8  received byte; stable while rx_data_valid=1.
rx_data_valid  output  1  byte available; held until accepted.
rx_data_ready  input  1  consumer accepts when rx_data_valid & rx_data_ready.
frame_error  output  1  one-cycle pulse: stop bit sampled 0.
overrun  output  1  one-cycle pulse: completed byte dropped because output was still full.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0; rx_data=8'h00, rx_data_valid=0, frame_error=0, overrun=0. Synchronizer flops preset to 1.
- Input path: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s, so there is 2 cycles of input latency.
- Bit counter cnt runs 0..DIV-1. The bit index idx runs 0..7.
- IDLE: when rx_s==0, clear cnt and go to START.
- START: count to (DIV/2)-1 and sample rx_s at that count.
  - Sample 1: glitch; return to IDLE with no output.
  - Sample 0: clear cnt, idx=0, go to DATA.
- DATA: at each cnt==DIV-1, sample rx_s into shift[idx] (LSB first) and clear cnt. After idx 7, go to STOP.
- STOP: at cnt==DIV-1, sample rx_s.
  - Sample 1: deliver byte (see below), go to IDLE.
  - Sample 0: pulse frame_error, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This stops a break condition from retriggering reception.
- Delivery happens the cycle after the stop sample:
  - rx_data_valid=0: load rx_data and set rx_data_valid=1.
  - rx_data_valid=1 and rx_data_ready=1 in the same cycle: the old byte counts as accepted, the new byte is loaded, and valid stays 1.
  - rx_data_valid=1 and rx_data_ready=0: the new byte is dropped, overrun pulses, and rx_data keeps the old byte.
- Handshake: rx_data_valid falls the cycle after a valid & ready acceptance, unless a simultaneous load occurs. rx_data_ready is a don't-care while valid=0.
- Timing: sampling falls mid-bit, with ±1 clk quantisation from the odd-DIV floor. Back-to-back frames with a 1-bit stop are supported because IDLE re-arms on the cycle after the stop sample.
- An async reset mid-frame aborts the frame immediately. No pulse is generated.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: each sample point (start, data, stop) takes the 2-of-3 majority of rx_s at cnt = target-1, target, target+1. The decision is registered at target+1, so delivery and error pulses are delayed by 1 clk. DIV >= 6 is required.
- Undefined: a single sample at the target count; no extra latency.

Decomposition:
- Package uart_pkg holds:
  - the typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;
  - localparam DATA_BITS=8;
  - a function that computes DIV and the counter width ($clog2(DIV)).
- Sub-module uart_sync (2-flop synchronizer, reset value parameterised to 1) is natural and reusable for other async inputs.

Test Plan:
(All at CLK_FREQ=100_000_000, BODE_RATE=10_000_000, DIV=10, clk period 10 ns.)
- Loopback single byte: uart_tx sends 8'hA5, rx_data_ready=1 -> one valid cycle with rx_data=8'hA5; frame_error=0 and overrun=0 throughout.
- Back-to-back bytes: uart_tx sends 8'hA5 then 8'hDD with no idle gap, ready=1 -> two acceptances, 8'hA5 then 8'hDD, no errors.
- Start glitch: drive rx low for 3 clks then high -> state returns to IDLE and rx_data_valid stays 0.
- Framing error: hand-drive 8'h3C with stop=0 for 10 bits, then hold low 50 clks -> frame_error pulses once, no valid, no re-trigger until rx returns to 1.
- Overrun: ready=0, send 8'h11 then 8'h22 -> valid=1 with rx_data=8'h11 and one overrun pulse. Raising ready then yields 8'h11 only.
- Reset mid-frame: assert rst=0 at data bit 4 of 8'hF0 -> all outputs reset immediately. After release, sending 8'h5A receives 8'h5A correctly.
